i2c_timer: RTL and testbench

I2C slave bus-phase timer. Tracks SCL edges between a START and a STOP and emits single-cycle phase strobes: per-bit shift strobe, byte received, ACK prepare, ACK check and ACK done. It sits between the SCL/SDA edge and START/STOP detectors and the slave controller FSM. The controller consumes `byte_received`, `ack_prep`, `check_ack` and `ack_done`; the RX shift register consumes `shift_strobe`.

---
 rtl/i2c_timer.sv | 130 +++++++++++++
 tb/tb_i2c_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_timer.sv
// I2C slave bus-phase timer: follows SCL edges between START and STOP and
// emits registered single-cycle strobes for data-bit shift, byte end and the ACK slot.
module i2c_timer #(
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic       start_found,
    input  logic       stop_found,
    output logic       shift_strobe,
    output logic       byte_received,
    output logic       ack_prep,
    output logic       check_ack,
    output logic       ack_done,
    output logic [3:0] bit_count,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_DATA          = 3'd1,
        S_ACK_PREP_WAIT = 3'd2,
        S_CHECK_WAIT    = 3'd3,
        S_DONE_WAIT     = 3'd4
    } state_t;

    localparam logic [3:0] LP_DATA_BITS = 4'(DATA_BITS);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_bit_count;
    logic [3:0] w_next_count;
    logic [3:0] w_count_inc;
    logic       r_shift;
    logic       r_byte;
    logic       r_prep;
    logic       r_check;
    logic       r_done;
    logic       w_shift;
    logic       w_byte;
    logic       w_prep;
    logic       w_check;
    logic       w_done;

    assign w_count_inc = r_bit_count + 4'd1;

    // STOP beats START beats edges; a rise hides a simultaneous fall.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_bit_count;
        w_shift      = 1'b0;
        w_byte       = 1'b0;
        w_prep       = 1'b0;
        w_check      = 1'b0;
        w_done       = 1'b0;
        if (stop_found) begin
            w_next_state = S_IDLE;
            w_next_count = 4'd0;
        end else if (start_found) begin
            w_next_state = S_DATA;
            w_next_count = 4'd0;
        end else begin
            case (r_state)
                S_DATA: begin
                    if (rising_edge_found) begin
                        w_shift      = 1'b1;
                        w_next_count = w_count_inc;
                        if (w_count_inc == LP_DATA_BITS) begin
                            w_byte       = 1'b1;
                            w_next_state = S_ACK_PREP_WAIT;
                        end
                    end
                end
                S_ACK_PREP_WAIT: begin
                    if (!rising_edge_found && falling_edge_found) begin
                        w_prep       = 1'b1;
                        w_next_state = S_CHECK_WAIT;
                    end
                end
                S_CHECK_WAIT: begin
                    if (rising_edge_found) begin
                        w_check      = 1'b1;
                        w_next_state = S_DONE_WAIT;
                    end
                end
                S_DONE_WAIT: begin
                    if (!rising_edge_found && falling_edge_found) begin
                        w_done       = 1'b1;
                        w_next_count = 4'd0;
                        w_next_state = S_DATA;
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_bit_count <= 4'd0;
            r_shift     <= 1'b0;
            r_byte      <= 1'b0;
            r_prep      <= 1'b0;
            r_check     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_bit_count <= w_next_count;
            r_shift     <= w_shift;
            r_byte      <= w_byte;
            r_prep      <= w_prep;
            r_check     <= w_check;
            r_done      <= w_done;
        end
    end

    assign shift_strobe  = r_shift;
    assign byte_received = r_byte;
    assign ack_prep      = r_prep;
    assign check_ack     = r_check;
    assign ack_done      = r_done;
    assign bit_count     = r_bit_count;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_i2c_timer.sv
// Bench for i2c_timer: a vector table plus hand-written multi-cycle sequences,
// with expected outputs queued at drive time and compared one cycle later.
module tb_i2c_timer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rise, fall, start, stop;
    logic       shift_strobe, byte_received, ack_prep, check_ack, ack_done;
    logic [3:0] bit_count;
    logic [2:0] dbg_state;

    i2c_timer #(.DATA_BITS(8)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .rising_edge_found  (rise),
        .falling_edge_found (fall),
        .start_found        (start),
        .stop_found         (stop),
        .shift_strobe       (shift_strobe),
        .byte_received      (byte_received),
        .ack_prep           (ack_prep),
        .check_ack          (check_ack),
        .ack_done           (ack_done),
        .bit_count          (bit_count),
        .dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;

    // state codes: 0 idle, 1 data, 2 ack_prep_wait, 3 check_wait, 4 done_wait
    // strobe order: shift, byte, prep, check, done
    typedef struct packed {
        logic [2:0] st;
        logic [4:0] stb;
        logic [3:0] cnt;
    } out_t;

    typedef struct {
        logic r, f, sa, so;
        out_t e;
    } vec_t;

    localparam logic [4:0] N  = 5'b00000;
    localparam logic [4:0] SH = 5'b10000;
    localparam logic [4:0] SB = 5'b11000;
    localparam logic [4:0] PR = 5'b00100;
    localparam logic [4:0] CK = 5'b00010;
    localparam logic [4:0] DN = 5'b00001;

    out_t exp_q[$];
    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic out_t o(input logic [2:0] st, input logic [4:0] stb, input logic [3:0] cnt);
        out_t r;
        r.st  = st;
        r.stb = stb;
        r.cnt = cnt;
        return r;
    endfunction

    function automatic vec_t v(input logic r, input logic f, input logic sa, input logic so, input out_t e);
        vec_t x;
        x.r  = r;
        x.f  = f;
        x.sa = sa;
        x.so = so;
        x.e  = e;
        return x;
    endfunction

    task automatic check_out(input string name);
        out_t a, e;
        a = {dbg_state, shift_strobe, byte_received, ack_prep, check_ack, ack_done, bit_count};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got %h, no expectation queued", name, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got st=%0d stb=%b cnt=%0d, expected st=%0d stb=%b cnt=%0d",
                         name, a.st, a.stb, a.cnt, e.st, e.stb, e.cnt);
            end
        end
    endtask

    task automatic step(input logic r, input logic f, input logic sa, input logic so,
                        input out_t e, input string name);
        rise  = r;
        fall  = f;
        start = sa;
        stop  = so;
        exp_q.push_back(e);
        @(negedge clk);
        rise  = 1'b0;
        fall  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        check_out(name);
    endtask

    // Full byte from DATA with count 0, including ACK slot, ending back in DATA.
    task automatic run_byte(input string tag);
        for (int b = 1; b <= 8; b++) begin
            step(0, 1, 0, 0, o(3'd1, N, 4'(b - 1)), {tag, "_fall"});
            step(1, 0, 0, 0, o((b == 8) ? 3'd2 : 3'd1, (b == 8) ? SB : SH, 4'(b)), {tag, "_rise"});
        end
        step(0, 1, 0, 0, o(3'd3, PR, 4'd8), {tag, "_ack_prep"});
        step(1, 0, 0, 0, o(3'd4, CK, 4'd8), {tag, "_check_ack"});
        step(0, 1, 0, 0, o(3'd1, DN, 4'd0), {tag, "_ack_done"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        rise  = 1'b0;
        fall  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(o(3'd0, N, 4'd0));
        check_out("reset_state");
        n_rst = 1'b1;

        // basic walk through one byte with corner vectors mixed in
        tbl.push_back(v(1, 0, 0, 0, o(3'd0, N, 4'd0)));  // idle ignores rise
        tbl.push_back(v(0, 1, 0, 0, o(3'd0, N, 4'd0)));  // idle ignores fall
        tbl.push_back(v(0, 0, 1, 0, o(3'd1, N, 4'd0)));  // start
        tbl.push_back(v(0, 1, 0, 0, o(3'd1, N, 4'd0)));  // first fall ignored
        tbl.push_back(v(1, 0, 0, 0, o(3'd1, SH, 4'd1)));
        tbl.push_back(v(1, 1, 0, 0, o(3'd1, SH, 4'd2))); // rise wins over fall
        tbl.push_back(v(1, 0, 0, 0, o(3'd1, SH, 4'd3)));
        tbl.push_back(v(1, 0, 0, 0, o(3'd1, SH, 4'd4)));
        tbl.push_back(v(1, 0, 0, 0, o(3'd1, SH, 4'd5)));
        tbl.push_back(v(1, 0, 0, 0, o(3'd1, SH, 4'd6)));
        tbl.push_back(v(1, 0, 0, 0, o(3'd1, SH, 4'd7)));
        tbl.push_back(v(1, 0, 0, 0, o(3'd2, SB, 4'd8))); // byte end
        tbl.push_back(v(1, 0, 0, 0, o(3'd2, N, 4'd8)));  // rise ignored, no wrap
        tbl.push_back(v(1, 1, 0, 0, o(3'd2, N, 4'd8)));  // rise+fall: no ack_prep
        tbl.push_back(v(0, 1, 0, 0, o(3'd3, PR, 4'd8)));
        tbl.push_back(v(0, 1, 0, 0, o(3'd3, N, 4'd8)));  // fall ignored
        tbl.push_back(v(1, 0, 0, 0, o(3'd4, CK, 4'd8)));
        tbl.push_back(v(1, 0, 0, 0, o(3'd4, N, 4'd8)));  // rise ignored
        tbl.push_back(v(1, 1, 0, 0, o(3'd4, N, 4'd8)));  // rise+fall: no ack_done
        tbl.push_back(v(0, 1, 0, 0, o(3'd1, DN, 4'd0)));
        tbl.push_back(v(0, 0, 0, 1, o(3'd0, N, 4'd0)));  // stop
        foreach (tbl[i]) step(tbl[i].r, tbl[i].f, tbl[i].sa, tbl[i].so, tbl[i].e, $sformatf("vec%0d", i));

        // two consecutive bytes
        step(0, 0, 1, 0, o(3'd1, N, 4'd0), "seq_start");
        run_byte("byte1");
        run_byte("byte2");

        // repeated START at bit_count 4
        for (int b = 1; b <= 4; b++)
            step(1, 0, 0, 0, o(3'd1, SH, 4'(b)), "rs_pre_rise");
        step(1, 0, 1, 0, o(3'd1, N, 4'd0), "rs_start_with_rise");
        for (int b = 1; b <= 8; b++)
            step(1, 0, 0, 0, o((b == 8) ? 3'd2 : 3'd1, (b == 8) ? SB : SH, 4'(b)), "rs_rise");

        // STOP while waiting for the ACK-slot rise
        step(0, 1, 0, 0, o(3'd3, PR, 4'd8), "sm_prep");
        step(1, 0, 0, 1, o(3'd0, N, 4'd0), "sm_stop_with_rise");
        step(1, 0, 0, 0, o(3'd0, N, 4'd0), "sm_rise_after_stop");

        // stop + start + rise together in DATA
        step(0, 0, 1, 0, o(3'd1, N, 4'd0), "sim_start");
        step(1, 0, 0, 0, o(3'd1, SH, 4'd1), "sim_rise");
        step(1, 0, 1, 1, o(3'd0, N, 4'd0), "sim_all");

        // async reset in the middle of a byte
        step(0, 0, 1, 0, o(3'd1, N, 4'd0), "rst_start");
        for (int b = 1; b <= 5; b++)
            step(1, 0, 0, 0, o(3'd1, SH, 4'(b)), "rst_rise");
        rise = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        exp_q.push_back(o(3'd0, N, 4'd0));
        check_out("rst_async");
        @(negedge clk);
        rise  = 1'b0;
        n_rst = 1'b1;
        step(1, 0, 0, 0, o(3'd0, N, 4'd0), "rst_rise_ignored");
        step(0, 1, 0, 0, o(3'd0, N, 4'd0), "rst_fall_ignored");
        step(0, 0, 1, 0, o(3'd1, N, 4'd0), "rst_new_start");
        step(1, 0, 0, 0, o(3'd1, SH, 4'd1), "rst_first_bit");

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL leftover: %0d expectations never compared, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
